multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
Parametrised multicycle MIPS control unit, successor to the single-cycle controller. A Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles and stalls on a memory-ready handshake. It adds bne/addi/j support, illegal-instruction trapping and a retired-instruction counter. It drives the multicycle datapath (shared memory, IR, A/B/ALUOut registers).

Parameters:
ALUCTRL_W, 3, alucontrol width (>=3); 3-bit code zero-extended.
ENABLE_BNE, 1, 1 decodes bne (000101); 0 traps on it.
ENABLE_J, 1, 1 decodes j (000010); 0 traps on it.
CNT_W, 32, retired-instruction counter width.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26], stable from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
iord  out  1  memory address select: 0=PC, 1=ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  IR load enable
regdst  out  1  1=rd, 0=rt
memtoreg  out  1  1=data register, 0=ALUOut
regwrite  out  1  register file write
alusrca  out  1  0=PC, 1=A
alusrcb  out  2  00=B, 01=4, 10=signimm, 11=signimm<<2
pcsrc  out  2  00=ALU, 01=ALUOut, 10=jump target
pcen  out  1  PC load enable
alucontrol  out  ALUCTRL_W  ALU operation
trap  out  1  illegal instruction, sticky
retire  out  1  one-cycle pulse when an instruction completes
instret  out  CNT_W  retired-instruction count

Behaviour:
- State register updates on posedge clk. Async reset_n=0 sets state=FETCH, instret=0, trap=0. All other outputs are combinational from state (Moore), plus op/funct/zero/mem_ready where noted.
- Unlisted outputs are 0 in every state.
- FETCH: alusrcb=01, pcsrc=00. irwrite=pcwrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alusrcb=11. Next state by op:
  - lw/sw (100011/101011) -> MEMADR
  - R (000000) with legal funct -> EXECUTE
  - beq (000100) -> BRANCH
  - bne, if enabled -> BRANCH
  - addi (001000) -> ADDIEX
  - j, if enabled -> JUMP
  - anything else, including R with an unknown funct or a disabled op -> TRAP
- MEMADR: alusrca=1, alusrcb=10. lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB: memtoreg=1, regwrite=1 -> FETCH (retire).
- MEMWR: iord=1, memwrite=1 held for every cycle in the state. When mem_ready=1 -> FETCH (retire).
- EXECUTE: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB: regdst=1, regwrite=1 -> FETCH (retire).
- BRANCH: alusrca=1, aluop=01, pcsrc=01. branch=1 for beq, bne=1 for bne -> FETCH (retire).
- ADDIEX: alusrca=1, alusrcb=10 -> ADDIWB.
- ADDIWB: regwrite=1 -> FETCH (retire).
- JUMP: pcsrc=10, pcwrite=1 -> FETCH (retire).
- TRAP: all strobes 0, trap=1. Terminal until reset_n.
- pcen = pcwrite | (branch & zero) | (bne & ~zero).
- alucontrol:
  - aluop 00 -> 010
  - aluop 01 -> 110
  - aluop 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
- retire is high during the final-state cycle whose next state is FETCH. instret increments on that edge and wraps modulo 2^CNT_W.
- Zero-wait latencies: lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3 cycles.
- Reset mid-instruction discards the instruction: no retire, no count.

Test Plan:
- lw, mem_ready low for 2 cycles in FETCH and 1 in MEMRD -> FETCH held 3 cycles with irwrite=pcen=0 until ready; total 8 cycles; regwrite=memtoreg=1 in MEMWB; instret 0->1.
- R-type funct 101010, mem_ready=1 -> FETCH, DECODE, EXECUTE(alucontrol=111), ALUWB(regdst=1, regwrite=1); retire pulses in ALUWB.
- beq with zero=1 -> pcen=1 in BRANCH; beq with zero=0 -> pcen=0; bne with zero=0 -> pcen=1; each 3 cycles.
- ENABLE_BNE=0, op=000101 -> TRAP after DECODE; trap=1, all strobes 0 for 10 cycles; reset_n pulse -> FETCH, trap=0.
- reset_n asserted asynchronously mid-MEMWR -> memwrite drops immediately; instret unchanged (0); restarts in FETCH.
- CNT_W=2, five back-to-back j -> instret sequence 1,2,3,0,1; pcsrc=10 in each JUMP.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Bundle between the multicycle control unit and its datapath.
// master: controller side (consumes IR fields / status, drives control strobes).
// slave : datapath side (drives IR fields / status, consumes control strobes).
//   op, funct      IR[31:26] and IR[5:0]
//   zero           ALU zero flag
//   mem_ready      memory access completes this cycle
//   iord..pcen     datapath control strobes and mux selects
//   alucontrol     ALU operation, 3-bit code zero-extended to ALUCTRL_W
//   trap           sticky illegal-instruction flag
//   retire         one-cycle pulse when an instruction completes
//   instret        retired-instruction count, wraps modulo 2^CNT_W
interface multicycle_controller_if #(
  parameter int unsigned ALUCTRL_W = 3,
  parameter int unsigned CNT_W     = 32
);
  logic [5:0]           op;
  logic [5:0]           funct;
  logic                 zero;
  logic                 mem_ready;

  logic                 iord;
  logic                 memwrite;
  logic                 irwrite;
  logic                 regdst;
  logic                 memtoreg;
  logic                 regwrite;
  logic                 alusrca;
  logic [1:0]           alusrcb;
  logic [1:0]           pcsrc;
  logic                 pcen;
  logic [ALUCTRL_W-1:0] alucontrol;
  logic                 trap;
  logic                 retire;
  logic [CNT_W-1:0]     instret;

  modport master (
    input  op, funct, zero, mem_ready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, pcen, alucontrol, trap, retire, instret
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, pcen, alucontrol, trap, retire, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit (Moore FSM).
// Sequences fetch / decode / execute / memory / writeback, stalls on the
// memory-ready handshake, traps illegal instructions and counts retirements.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (state=FETCH, instret=0, trap=0)
//   bus      multicycle_controller_if.master, see the interface header
module multicycle_controller #(
  parameter int unsigned ALUCTRL_W  = 3,
  parameter bit          ENABLE_BNE = 1'b1,
  parameter bit          ENABLE_J   = 1'b1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  multicycle_controller_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_TRAP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               trap_q, trap_d;

  logic [1:0]         aluop;
  logic               pcwrite;
  logic               branch;
  logic               bne_br;
  logic               funct_legal;
  logic [2:0]         alu3;
  logic               retire;

  always_comb begin
    funct_legal = 1'b0;
    unique case (bus.funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_legal = 1'b1;
      default:                               funct_legal = 1'b0;
    endcase
  end

  // Next-state and Moore control outputs
  always_comb begin
    state_d      = state_q;
    aluop        = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    bne_br       = 1'b0;
    bus.iord     = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;

    unique case (state_q)
      S_FETCH: begin
        bus.alusrcb = 2'b01;
        bus.pcsrc   = 2'b00;
        // IR load and PC+4 only take effect once memory delivers the word
        bus.irwrite = bus.mem_ready;
        pcwrite     = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        bus.alusrcb = 2'b11;
        unique case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_legal ? S_EXECUTE : S_TRAP;
          OP_BEQ:       state_d = S_BRANCH;
          OP_BNE:       state_d = ENABLE_BNE ? S_BRANCH : S_TRAP;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = ENABLE_J ? S_JUMP : S_TRAP;
          default:      state_d = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        bus.iord = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end

      S_EXECUTE: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b00;
        aluop       = 2'b10;
        state_d     = S_ALUWB;
      end

      S_ALUWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
        state_d      = S_FETCH;
      end

      S_BRANCH: begin
        bus.alusrca = 1'b1;
        aluop       = 2'b01;
        bus.pcsrc   = 2'b01;
        branch      = (bus.op == OP_BEQ);
        bne_br      = ENABLE_BNE && (bus.op == OP_BNE);
        state_d     = S_FETCH;
      end

      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = S_ADDIWB;
      end

      S_ADDIWB: begin
        bus.regwrite = 1'b1;
        state_d      = S_FETCH;
      end

      S_JUMP: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
        state_d   = S_FETCH;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  // ALU decoder
  always_comb begin
    alu3 = 3'b010;
    unique case (aluop)
      2'b00: alu3 = 3'b010;
      2'b01: alu3 = 3'b110;
      2'b10: begin
        unique case (bus.funct)
          FN_ADD:  alu3 = 3'b010;
          FN_SUB:  alu3 = 3'b110;
          FN_AND:  alu3 = 3'b000;
          FN_OR:   alu3 = 3'b001;
          FN_SLT:  alu3 = 3'b111;
          default: alu3 = 3'b010;
        endcase
      end
      default: alu3 = 3'b010;
    endcase
    bus.alucontrol      = '0;
    bus.alucontrol[2:0] = alu3;
  end

  // An instruction retires in the last cycle before returning to FETCH;
  // FETCH itself loops back while stalled and never counts.
  assign retire = (state_q != S_FETCH) && (state_d == S_FETCH);

  always_comb begin
    bus.pcen    = pcwrite | (branch & bus.zero) | (bne_br & ~bus.zero);
    bus.retire  = retire;
    bus.trap    = trap_q;
    bus.instret = instret_q;
  end

  always_comb begin
    instret_d = instret_q + CNT_W'(retire);
    trap_d    = trap_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
    end
  end

endmodule
